// File: rtl/conv3x3.sv
// rtl/conv3x3.sv - 3-stage pipelined 3x3 convolution MAC with saturating 18-bit output
// Define CONV3X3_RELU_EN to clamp negative results to zero after saturation.
module conv3x3 #(
  parameter int PIPE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in_valid,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  input  logic [7:0]  data_in_2,
  input  logic [7:0]  data_in_3,
  input  logic [7:0]  data_in_4,
  input  logic [7:0]  data_in_5,
  input  logic [7:0]  data_in_6,
  input  logic [7:0]  data_in_7,
  input  logic [7:0]  data_in_8,
  input  logic        weight_en,
  input  logic [7:0]  bias_data,
  input  logic [71:0] weights_data,
  output logic        data_out_valid,
  output logic [17:0] data_out
);

  logic [7:0]         pix [9];
  logic signed [7:0]  w_q [9];
  logic signed [7:0]  bias_q;

  logic signed [16:0] prod_d [9];
  logic signed [16:0] prod_q [9];
  logic signed [7:0]  bias1_q;

  logic signed [18:0] row_d [3];
  logic signed [18:0] row_q [3];
  logic signed [7:0]  bias2_q;

  logic signed [20:0] sum_d;
  logic signed [17:0] sat_d;
  logic signed [17:0] res_d;
  logic signed [17:0] data_out_q;

  logic [PIPE_LAT-1:0] vld_q;

  assign pix[0] = data_in_0;
  assign pix[1] = data_in_1;
  assign pix[2] = data_in_2;
  assign pix[3] = data_in_3;
  assign pix[4] = data_in_4;
  assign pix[5] = data_in_5;
  assign pix[6] = data_in_6;
  assign pix[7] = data_in_7;
  assign pix[8] = data_in_8;

  function automatic logic signed [18:0] ext19(input logic signed [16:0] p);
    return {{2{p[16]}}, p};
  endfunction

  function automatic logic signed [20:0] ext21(input logic signed [18:0] r);
    return {{2{r[18]}}, r};
  endfunction

  // Kernel registers update at the same edge the current window is sampled,
  // so a window coinciding with weight_en still sees the old kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
      bias_q <= '0;
    end else if (weight_en) begin
      for (int k = 0; k < 9; k++) w_q[k] <= weights_data[71-8*k -: 8];
      bias_q <= bias_data;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({9'b0, pix[k]}) * $signed({{9{w_q[k][7]}}, w_q[k]});
    end
  end

  // Bias travels with its window so a reload never affects results in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      bias1_q <= '0;
    end else begin
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      bias1_q <= bias_q;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_d[r] = ext19(prod_q[3*r]) + ext19(prod_q[3*r+1]) + ext19(prod_q[3*r+2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) row_q[r] <= '0;
      bias2_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
      bias2_q <= bias1_q;
    end
  end

  always_comb begin
    sum_d = ext21(row_q[0]) + ext21(row_q[1]) + ext21(row_q[2])
          + {{13{bias2_q[7]}}, bias2_q};
    sat_d = sum_d[17:0];
    if (sum_d > 21'sd131071) begin
      sat_d = 18'sd131071;
    end else if (sum_d < -21'sd131072) begin
      sat_d = -18'sd131072;
    end
`ifdef CONV3X3_RELU_EN
    res_d = sat_d[17] ? '0 : sat_d;
`else
    res_d = sat_d;
`endif
  end

  // Output register only loads on a valid result so it holds between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (vld_q[PIPE_LAT-2]) begin
      data_out_q <= res_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[PIPE_LAT-2:0], data_in_valid};
    end
  end

  assign data_out_valid = vld_q[PIPE_LAT-1];
  assign data_out       = data_out_q;

endmodule

// File: tb/tb_conv3x3.sv
// tb/tb_conv3x3.sv - table-driven and randomized self-checking bench for conv3x3
module tb_conv3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_in_valid;
  logic [71:0] pix_drv;
  logic        weight_en;
  logic [7:0]  bias_data;
  logic [71:0] weights_data;
  logic        data_out_valid;
  logic [17:0] data_out;

  int total = 0;
  int bad   = 0;

  conv3x3 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_valid  (data_in_valid),
    .data_in_0      (pix_drv[71:64]),
    .data_in_1      (pix_drv[63:56]),
    .data_in_2      (pix_drv[55:48]),
    .data_in_3      (pix_drv[47:40]),
    .data_in_4      (pix_drv[39:32]),
    .data_in_5      (pix_drv[31:24]),
    .data_in_6      (pix_drv[23:16]),
    .data_in_7      (pix_drv[15:8]),
    .data_in_8      (pix_drv[7:0]),
    .weight_en      (weight_en),
    .bias_data      (bias_data),
    .weights_data   (weights_data),
    .data_out_valid (data_out_valid),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        load;
    logic        same;
    logic [71:0] w;
    logic [7:0]  b;
    logic [71:0] pix;
    logic signed [17:0] e;
  } vec_t;

  localparam logic [71:0] K1 = 72'h01_01_01_01_02_01_01_01_01;
  localparam logic [71:0] K2 = 72'h02_02_02_02_02_02_02_02_02;
  localparam logic [71:0] KP = 72'h7F_7F_7F_7F_7F_7F_7F_7F_7F;
  localparam logic [71:0] KN = 72'h80_80_80_80_80_80_80_80_80;

  vec_t vt [26];

  // Reference state: kernel in effect, expected results in order, arrival times.
  logic [71:0] mk_w = '0;
  logic [7:0]  mk_b = '0;
  int          exp_q [$];
  logic [2:0]  mv = '0;
  int          last_out = 0;

  function automatic int pixval(input int kind, input int y, input int x);
    case (kind)
      0:       return y * 5 + x + 1;
      1:       return ((y + x) % 2 == 0) ? 2 : 1;
      2:       return (y >= 1 && y <= 3 && x >= 1 && x <= 3) ? 10 : 1;
      default: return 255;
    endcase
  endfunction

  function automatic logic [71:0] win(input int kind, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[71-8*k -: 8] = 8'(pixval(kind, r + k / 3, c + k % 3));
    return v;
  endfunction

  function automatic int model(input logic [71:0] p, input logic [71:0] w, input logic [7:0] b);
    int s;
    logic [7:0] pk, wk;
    s = int'($signed(b));
    for (int k = 0; k < 9; k++) begin
      pk = p[71-8*k -: 8];
      wk = w[71-8*k -: 8];
      s += int'(pk) * int'($signed(wk));
    end
    if (s > 131071) s = 131071;
    else if (s < -131072) s = -131072;
`ifdef CONV3X3_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic check_out();
    chk("valid", int'(data_out_valid), int'(mv[2]));
    if (mv[2]) begin
      last_out = exp_q.pop_front();
      chk("data", int'($signed(data_out)), last_out);
    end else begin
      chk("hold", int'($signed(data_out)), last_out);
    end
  endtask

  task automatic cycle(input logic v, input logic [71:0] pix, input logic we,
                       input logic [71:0] w, input logic [7:0] b,
                       input logic use_tab, input int e);
    data_in_valid = v;
    pix_drv       = pix;
    weight_en     = we;
    weights_data  = w;
    bias_data     = b;
    if (v) exp_q.push_back(use_tab ? e : model(pix, mk_w, mk_b));
    if (we) begin
      mk_w = w;
      mk_b = b;
    end
    mv = {mv[1:0], v};
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 0);
  endtask

  initial begin
    int ramp_e [9];
    int chk_e  [9];
    int ix;
    logic [95:0] r96;
    logic [71:0] rp, rw;

    ramp_e = '{70, 80, 90, 120, 130, 140, 170, 180, 190};
    chk_e  = '{16, 14, 16, 14, 16, 14, 16, 14, 16};
    ix = 0;
    for (int i = 0; i < 9; i++) begin
      vt[ix] = '{load: (i == 0), same: 1'b0, w: K1, b: 8'h00,
                 pix: win(0, i / 3, i % 3), e: 18'(ramp_e[i])};
      ix++;
    end
    for (int i = 0; i < 9; i++) begin
      vt[ix] = '{load: 1'b0, same: 1'b0, w: K1, b: 8'h00,
                 pix: win(1, i / 3, i % 3), e: 18'(chk_e[i])};
      ix++;
    end
    vt[18] = '{load: 1'b0, same: 1'b0, w: K1, b: 8'h00, pix: win(2, 0, 0), e: 18'sd55};
    vt[19] = '{load: 1'b0, same: 1'b0, w: K1, b: 8'h00, pix: win(2, 1, 1), e: 18'sd100};
    vt[20] = '{load: 1'b0, same: 1'b0, w: K1, b: 8'h00, pix: win(2, 2, 2), e: 18'sd55};
    vt[21] = '{load: 1'b1, same: 1'b0, w: KP, b: 8'h00, pix: win(3, 0, 0), e: 18'sd131071};
`ifdef CONV3X3_RELU_EN
    vt[22] = '{load: 1'b1, same: 1'b0, w: KN, b: 8'h00, pix: win(3, 0, 0), e: 18'sd0};
`else
    vt[22] = '{load: 1'b1, same: 1'b0, w: KN, b: 8'h00, pix: win(3, 0, 0), e: -18'sd131072};
`endif
    vt[23] = '{load: 1'b1, same: 1'b0, w: K1, b: 8'hFB, pix: win(0, 0, 0), e: 18'sd65};
    vt[24] = '{load: 1'b1, same: 1'b1, w: K2, b: 8'h03, pix: win(0, 0, 0), e: 18'sd65};
    vt[25] = '{load: 1'b0, same: 1'b0, w: K2, b: 8'h03, pix: win(0, 0, 0), e: 18'sd129};

    rst_n = 1'b0;
    data_in_valid = 1'b0;
    pix_drv = '0;
    weight_en = 1'b0;
    weights_data = '0;
    bias_data = '0;
    #12;
    chk("reset_valid", int'(data_out_valid), 0);
    chk("reset_data", int'($signed(data_out)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 26; i++) begin
      if (vt[i].load && !vt[i].same) cycle(1'b0, '0, 1'b1, vt[i].w, vt[i].b, 1'b0, 0);
      cycle(1'b1, vt[i].pix, vt[i].load && vt[i].same, vt[i].w, vt[i].b, 1'b1, int'(vt[i].e));
    end
    idle(4);

    // Reset with results in flight: output drops at once and nothing stale appears.
    cycle(1'b1, win(0, 0, 1), 1'b0, '0, '0, 1'b0, 0);
    cycle(1'b1, win(0, 1, 1), 1'b0, '0, '0, 1'b0, 0);
    cycle(1'b1, win(0, 2, 2), 1'b0, '0, '0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    data_in_valid = 1'b0;
    #1;
    chk("rst_mid_valid", int'(data_out_valid), 0);
    chk("rst_mid_data", int'($signed(data_out)), 0);
    mv = '0;
    exp_q.delete();
    last_out = 0;
    mk_w = '0;
    mk_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    cycle(1'b1, win(0, 1, 1), 1'b0, '0, '0, 1'b1, 0);
    idle(2);
    cycle(1'b0, '0, 1'b1, K1, 8'h00, 1'b0, 0);
    cycle(1'b1, win(0, 1, 1), 1'b0, '0, '0, 1'b1, 130);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      rp = r96[71:0];
      r96 = {$urandom, $urandom, $urandom};
      rw = r96[71:0];
      cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 7) == 0, rw,
            8'($urandom), 1'b0, 0);
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
